// File: rtl/read_arbiter_if.sv
// ---------------------------------------------------------------------------
// read_arbiter_if
//   One read channel: an address request handshake followed, in order, by a
//   read-data handshake.
//
//   Handshake rule (both halves): a transfer happens on a rising clock edge
//   where valid && ready are both 1. Once valid is raised it is held, with a
//   stable payload, until that transfer.
//
//   Signals
//     addr_valid / addr_ready / addr   request from master to slave
//     data_valid / data_ready / data   read data from slave to master
//   Modports
//     master  issues requests and accepts data (memory-side port of the arbiter)
//     slave   accepts requests and returns data (core-side ports of the arbiter)
// ---------------------------------------------------------------------------
interface read_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  addr_valid;
    logic                  addr_ready;
    logic [DATA_WIDTH-1:0] addr;
    logic                  data_valid;
    logic                  data_ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (
        output addr_valid, addr, data_ready,
        input  addr_ready, data_valid, data
    );

    modport slave (
        input  addr_valid, addr, data_ready,
        output addr_ready, data_valid, data
    );
endinterface

// File: rtl/read_arbiter.sv
// ---------------------------------------------------------------------------
// read_arbiter
//   Arbitrates the instruction-read (ir) and data-read (dr) channels onto the
//   single memory read channel (m). The source of every accepted request is
//   pushed into an ID FIFO; read data coming back from memory is steered to
//   the source at the FIFO head, so responses return in request order.
//
//   Optional feature macro: READ_ARB_ROUND_ROBIN_EN
//     defined   - on a tie, grant the source that was not granted last
//     undefined - on a tie, IR always wins (last grant is still tracked)
//
//   Ports
//     clk, rst        clock, synchronous active-high reset
//     ir, dr          core-side read channels (slave modport)
//     m               memory-side read channel (master modport)
//     outstanding     ID FIFO occupancy
//     proto_err       sticky: memory data seen while nothing was outstanding
//     dbg_lock        request lock state (held until the memory accepts)
//     dbg_last_grant  last granted source, 0 = IR, 1 = DR
// ---------------------------------------------------------------------------
module read_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUTST  = 4,
    parameter int PTR_W      = $clog2(MAX_OUTST)
) (
    input  logic             clk,
    input  logic             rst,
    read_arbiter_if.slave    ir,
    read_arbiter_if.slave    dr,
    read_arbiter_if.master   m,
    output logic [PTR_W:0]   outstanding,
    output logic             proto_err,
    output logic             dbg_lock,
    output logic             dbg_last_grant
);

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_IR   = 2'd1,
        SEL_DR   = 2'd2
    } sel_e;

    typedef enum logic {
        SRC_IR = 1'b0,
        SRC_DR = 1'b1
    } src_e;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(MAX_OUTST);

    // Registered state
    logic                 lock_q,       lock_d;
    src_e                 lock_src_q,   lock_src_d;
    src_e                 last_grant_q, last_grant_d;
    logic [MAX_OUTST-1:0] fifo_q,       fifo_d;      // one source bit per entry
    logic [PTR_W-1:0]     wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q,     rd_ptr_d;
    logic [PTR_W:0]       count_q,      count_d;
    logic                 proto_err_q,  proto_err_d;

    // Combinational
    sel_e sel;
    src_e sel_src;
    src_e head;
    logic full;
    logic empty;
    logic push;
    logic pop;

    always_comb begin
        full  = (count_q == FULL_CNT);
        empty = (count_q == '0);

        // Grant selection. A locked request keeps its source until accepted so
        // memory sees a stable valid/address.
        sel = SEL_NONE;
        if (lock_q) begin
            sel = (lock_src_q == SRC_DR) ? SEL_DR : SEL_IR;
        end else if (ir.addr_valid && dr.addr_valid) begin
`ifdef READ_ARB_ROUND_ROBIN_EN
            sel = (last_grant_q == SRC_IR) ? SEL_DR : SEL_IR;
`else
            sel = SEL_IR;
`endif
        end else if (ir.addr_valid) begin
            sel = SEL_IR;
        end else if (dr.addr_valid) begin
            sel = SEL_DR;
        end
        sel_src = (sel == SEL_DR) ? SRC_DR : SRC_IR;

        // Request path. No push while full, even if a pop happens this cycle.
        m.addr_valid  = (sel != SEL_NONE) && !full;
        m.addr        = (sel == SEL_IR) ? ir.addr :
                        (sel == SEL_DR) ? dr.addr : '0;
        ir.addr_ready = (sel == SEL_IR) && !full && m.addr_ready;
        dr.addr_ready = (sel == SEL_DR) && !full && m.addr_ready;

        // Response path: only the FIFO head source sees memory data.
        head          = src_e'(fifo_q[rd_ptr_q]);
        ir.data_valid = 1'b0;
        ir.data       = '0;
        dr.data_valid = 1'b0;
        dr.data       = '0;
        m.data_ready  = 1'b0;
        if (!empty) begin
            if (head == SRC_IR) begin
                ir.data_valid = m.data_valid;
                ir.data       = m.data;
                m.data_ready  = ir.data_ready;
            end else begin
                dr.data_valid = m.data_valid;
                dr.data       = m.data;
                m.data_ready  = dr.data_ready;
            end
        end

        push = m.addr_valid && m.addr_ready;
        pop  = m.data_valid && m.data_ready;

        // Next state
        lock_d       = m.addr_valid && !m.addr_ready;
        lock_src_d   = m.addr_valid ? sel_src : lock_src_q;
        last_grant_d = push ? sel_src : last_grant_q;

        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = sel_src;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        proto_err_d = proto_err_q || (m.data_valid && empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q       <= 1'b0;
            lock_src_q   <= SRC_IR;
            last_grant_q <= SRC_DR;
            fifo_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            lock_src_q   <= lock_src_d;
            last_grant_q <= last_grant_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign outstanding    = count_q;
    assign proto_err      = proto_err_q;
    assign dbg_lock       = lock_q;
    assign dbg_last_grant = last_grant_q;

endmodule

// File: tb/tb_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_read_arbiter
//   Directed bench for read_arbiter. Inputs change 1 ns after the rising
//   edge; outputs are compared 1 ns later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_read_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] outstanding;
    logic       proto_err;
    logic       dbg_lock;
    logic       dbg_last_grant;

    int tests_run    = 0;
    int tests_failed = 0;

    // expected response source per outstanding read, 0 = IR, 1 = DR
    logic [0:0] exp_q[$];

    read_arbiter_if #(.DATA_WIDTH(32)) ir_if ();
    read_arbiter_if #(.DATA_WIDTH(32)) dr_if ();
    read_arbiter_if #(.DATA_WIDTH(32)) m_if ();

    read_arbiter #(.DATA_WIDTH(32), .MAX_OUTST(4), .PTR_W(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .ir             (ir_if),
        .dr             (dr_if),
        .m              (m_if),
        .outstanding    (outstanding),
        .proto_err      (proto_err),
        .dbg_lock       (dbg_lock),
        .dbg_last_grant (dbg_last_grant)
    );

    // clock / reset
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ir_if.addr_valid = 1'b0; ir_if.addr = '0; ir_if.data_ready = 1'b0;
        dr_if.addr_valid = 1'b0; dr_if.addr = '0; dr_if.data_ready = 1'b0;
        m_if.addr_ready  = 1'b0; m_if.data_valid = 1'b0; m_if.data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Returns one read from memory and checks it lands on the expected side.
    task automatic drain_one(input logic [31:0] data, input string name);
        logic [0:0]  src;
        logic        got_v;
        logic        oth_v;
        logic [31:0] got_d;
        src = exp_q.pop_front();
        ir_if.data_ready = 1'b1;
        dr_if.data_ready = 1'b1;
        m_if.data_valid  = 1'b1;
        m_if.data        = data;
        #1;
        got_v = src[0] ? dr_if.data_valid : ir_if.data_valid;
        got_d = src[0] ? dr_if.data       : ir_if.data;
        oth_v = src[0] ? ir_if.data_valid : dr_if.data_valid;
        tests_run++;
        if ({got_v, oth_v, got_d} !== {1'b1, 1'b0, data}) begin
            tests_failed++;
            $display("FAIL %s: src=%0d valid/other/data got %b/%b/%h expected 1/0/%h",
                     name, src, got_v, oth_v, got_d, data);
        end
        step();
        m_if.data_valid = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        #1;
        tests_run++;
        if (outstanding !== 3'd0 || proto_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_status: outstanding=%0d proto_err=%b expected 0/0", outstanding, proto_err);
        end
        tests_run++;
        if ({m_if.addr_valid, ir_if.addr_ready, dr_if.addr_ready, m_if.data_ready} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_handshake: got %b expected 0000",
                     {m_if.addr_valid, ir_if.addr_ready, dr_if.addr_ready, m_if.data_ready});
        end
        tests_run++;
        if ({ir_if.data_valid, dr_if.data_valid, m_if.addr, ir_if.data, dr_if.data} !== 98'b0) begin
            tests_failed++;
            $display("FAIL reset_data: got valids %b%b addr %h ird %h drd %h expected all 0",
                     ir_if.data_valid, dr_if.data_valid, m_if.addr, ir_if.data, dr_if.data);
        end
        tests_run++;
        if (dbg_lock !== 1'b0 || dbg_last_grant !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_state: lock=%b last_grant=%b expected 0/1", dbg_lock, dbg_last_grant);
        end
    endtask

    task automatic test_single_ir();
        do_reset();
        ir_if.addr_valid = 1'b1;
        ir_if.addr       = 32'h100;
        m_if.addr_ready  = 1'b1;
        #1;
        tests_run++;
        if ({m_if.addr_valid, ir_if.addr_ready, dr_if.addr_ready, m_if.addr} !== {3'b110, 32'h100}) begin
            tests_failed++;
            $display("FAIL single_req: mv/irr/drr=%b%b%b addr=%h expected 110/00000100",
                     m_if.addr_valid, ir_if.addr_ready, dr_if.addr_ready, m_if.addr);
        end
        step();
        ir_if.addr_valid = 1'b0;
        m_if.addr_ready  = 1'b0;
        tests_run++;
        if (outstanding !== 3'd1) begin
            tests_failed++;
            $display("FAIL single_outst1: got %0d expected 1", outstanding);
        end
        exp_q.push_back(1'b0);
        drain_one(32'hDEADBEEF, "single_data");
        tests_run++;
        if (outstanding !== 3'd0 || dr_if.data_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_outst0: outstanding=%0d dr_valid=%b expected 0/0", outstanding, dr_if.data_valid);
        end
    endtask

    task automatic test_arbitration();
        logic [31:0] exp_addr;
        logic        exp_dr;
        do_reset();
        ir_if.addr_valid = 1'b1; ir_if.addr = 32'h200;
        dr_if.addr_valid = 1'b1; dr_if.addr = 32'h300;
        m_if.addr_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef READ_ARB_ROUND_ROBIN_EN
            exp_dr = (i % 2) == 1;
`else
            exp_dr = 1'b0;
`endif
            exp_addr = exp_dr ? 32'h300 : 32'h200;
            #1;
            tests_run++;
            if ({m_if.addr, ir_if.addr_ready, dr_if.addr_ready} !== {exp_addr, !exp_dr, exp_dr}) begin
                tests_failed++;
                $display("FAIL arb_grant%0d: addr=%h irr=%b drr=%b expected %h/%b/%b",
                         i, m_if.addr, ir_if.addr_ready, dr_if.addr_ready, exp_addr, !exp_dr, exp_dr);
            end
            exp_q.push_back(exp_dr);
            step();
        end
        ir_if.addr_valid = 1'b0;
        dr_if.addr_valid = 1'b0;
        tests_run++;
        if (outstanding !== 3'd4) begin
            tests_failed++;
            $display("FAIL arb_outst: got %0d expected 4", outstanding);
        end
        for (int i = 0; i < 4; i++) drain_one(32'hA0 + i, "arb_resp");
    endtask

    task automatic test_lock();
        do_reset();
        dr_if.addr_valid = 1'b1; dr_if.addr = 32'h400;
        step();
        tests_run++;
        if (dbg_lock !== 1'b1 || m_if.addr !== 32'h400 || dr_if.addr_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_set: lock=%b addr=%h drr=%b expected 1/400/0", dbg_lock, m_if.addr, dr_if.addr_ready);
        end
        ir_if.addr_valid = 1'b1; ir_if.addr = 32'h500;
        step();
        tests_run++;
        if (m_if.addr !== 32'h400 || ir_if.addr_ready !== 1'b0 || dbg_lock !== 1'b1) begin
            tests_failed++;
            $display("FAIL lock_hold: addr=%h irr=%b lock=%b expected 400/0/1", m_if.addr, ir_if.addr_ready, dbg_lock);
        end
        step();
        m_if.addr_ready = 1'b1;
        #1;
        tests_run++;
        if (dr_if.addr_ready !== 1'b1 || ir_if.addr_ready !== 1'b0 || m_if.addr !== 32'h400) begin
            tests_failed++;
            $display("FAIL lock_release: drr=%b irr=%b addr=%h expected 1/0/400",
                     dr_if.addr_ready, ir_if.addr_ready, m_if.addr);
        end
        exp_q.push_back(1'b1);
        step();
        dr_if.addr_valid = 1'b0;
        #1;
        tests_run++;
        if (ir_if.addr_ready !== 1'b1 || m_if.addr !== 32'h500 || dbg_lock !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_next: irr=%b addr=%h lock=%b expected 1/500/0", ir_if.addr_ready, m_if.addr, dbg_lock);
        end
        exp_q.push_back(1'b0);
        step();
        ir_if.addr_valid = 1'b0;
        m_if.addr_ready  = 1'b0;
        drain_one(32'h1111, "lock_resp_dr");
        drain_one(32'h2222, "lock_resp_ir");
    endtask

    task automatic test_full();
        do_reset();
        m_if.addr_ready  = 1'b1;
        ir_if.addr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ir_if.addr = 32'h600 + 32'(i * 4);
            exp_q.push_back(1'b0);
            step();
        end
        ir_if.addr = 32'h610;
        #1;
        tests_run++;
        if (outstanding !== 3'd4 || ir_if.addr_ready !== 1'b0 || m_if.addr_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_block: outst=%0d irr=%b mv=%b expected 4/0/0",
                     outstanding, ir_if.addr_ready, m_if.addr_valid);
        end
        // pop while full: no push in the same cycle
        ir_if.data_ready = 1'b1;
        m_if.data_valid  = 1'b1;
        m_if.data        = 32'h600;
        #1;
        tests_run++;
        if (ir_if.addr_ready !== 1'b0 || ir_if.data_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_no_fallthru: irr=%b ir_dv=%b expected 0/1", ir_if.addr_ready, ir_if.data_valid);
        end
        void'(exp_q.pop_front());
        step();
        m_if.data_valid = 1'b0;
        #1;
        tests_run++;
        if (outstanding !== 3'd3 || ir_if.addr_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_after_pop: outst=%0d irr=%b expected 3/1", outstanding, ir_if.addr_ready);
        end
        exp_q.push_back(1'b0);
        step();
        ir_if.addr_valid = 1'b0;
        tests_run++;
        if (outstanding !== 3'd4) begin
            tests_failed++;
            $display("FAIL full_refill: got %0d expected 4", outstanding);
        end
        for (int i = 0; i < 4; i++) drain_one(32'h6100 + i, "full_resp");
        tests_run++;
        if (outstanding !== 3'd0) begin
            tests_failed++;
            $display("FAIL full_drained: got %0d expected 0", outstanding);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        m_if.addr_ready = 1'b1;
        ir_if.addr_valid = 1'b1; ir_if.addr = 32'h700; exp_q.push_back(1'b0); step();
        ir_if.addr_valid = 1'b0;
        dr_if.addr_valid = 1'b1; dr_if.addr = 32'h704; exp_q.push_back(1'b1); step();
        dr_if.addr_valid = 1'b0;
        ir_if.addr_valid = 1'b1; ir_if.addr = 32'h708; exp_q.push_back(1'b0); step();
        ir_if.addr_valid = 1'b0;
        m_if.addr_ready  = 1'b0;
        ir_if.data_ready = 1'b0;
        dr_if.data_ready = 1'b1;
        m_if.data_valid  = 1'b1;
        m_if.data        = 32'h11;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests_run++;
            if ({m_if.data_ready, ir_if.data_valid, dr_if.data_valid, ir_if.data} !== {3'b010, 32'h11}) begin
                tests_failed++;
                $display("FAIL bp_stall%0d: mdr/irv/drv=%b%b%b data=%h expected 010/00000011",
                         i, m_if.data_ready, ir_if.data_valid, dr_if.data_valid, ir_if.data);
            end
            step();
        end
        tests_run++;
        if (outstanding !== 3'd3) begin
            tests_failed++;
            $display("FAIL bp_held: got %0d expected 3", outstanding);
        end
        drain_one(32'h11, "bp_resp0");
        drain_one(32'h22, "bp_resp1");
        drain_one(32'h33, "bp_resp2");
        tests_run++;
        if (outstanding !== 3'd0) begin
            tests_failed++;
            $display("FAIL bp_drained: got %0d expected 0", outstanding);
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        m_if.addr_ready = 1'b1;
        ir_if.addr_valid = 1'b1; ir_if.addr = 32'h800; step();
        ir_if.addr_valid = 1'b0;
        dr_if.addr_valid = 1'b1; dr_if.addr = 32'h804; step();
        dr_if.addr_valid = 1'b0;
        m_if.addr_ready  = 1'b0;
        tests_run++;
        if (outstanding !== 3'd2) begin
            tests_failed++;
            $display("FAIL midrst_pre: got %0d expected 2", outstanding);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests_run++;
        if (outstanding !== 3'd0 || proto_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_clear: outst=%0d perr=%b expected 0/0", outstanding, proto_err);
        end
        ir_if.data_ready = 1'b1;
        dr_if.data_ready = 1'b1;
        m_if.data_valid  = 1'b1;
        m_if.data        = 32'hBAD;
        #1;
        tests_run++;
        if ({m_if.data_ready, ir_if.data_valid, dr_if.data_valid} !== 3'b000) begin
            tests_failed++;
            $display("FAIL midrst_empty: mdr/irv/drv=%b%b%b expected 000",
                     m_if.data_ready, ir_if.data_valid, dr_if.data_valid);
        end
        step();
        m_if.data_valid = 1'b0;
        tests_run++;
        if (proto_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_perr: got %b expected 1", proto_err);
        end
        step();
        step();
        tests_run++;
        if (proto_err !== 1'b1 || outstanding !== 3'd0) begin
            tests_failed++;
            $display("FAIL midrst_sticky: perr=%b outst=%0d expected 1/0", proto_err, outstanding);
        end
    endtask

    // sequence and final report
    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_ir();
        test_arbitration();
        test_lock();
        test_full();
        test_backpressure();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
